// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice per clock, LS nibble first, carry registered between nibbles.
// Optional macro NIBBLE_ADD_SUB_EN adds a 'sub' input that turns the operation into a - b.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    counter;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Four chained full adders; returns {carry_out, sum[3:0]}.
    function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] s;
        logic       c;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    always_comb begin
        {slice_cout, slice_sum} = slice_add(op_a[3:0], op_b[3:0], carry);
    end

`ifdef NIBBLE_ADD_SUB_EN
    // Subtraction as a + ~b + 1; cout then reads as "no borrow".
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? 1'b1 : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            counter   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a     <= a;
                        op_b     <= b_eff;
                        carry    <= cin_eff;
                        counter  <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    sum     <= {slice_sum, sum[WIDTH-1:4]};
                    op_a    <= {4'b0000, op_a[WIDTH-1:4]};
                    op_b    <= {4'b0000, op_b[WIDTH-1:4]};
                    carry   <= slice_cout;
                    counter <= counter + CW'(1);
                    if (counter == CW'(N - 1)) begin
                        state     <= DONE;
                        cout      <= slice_cout;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // No bypass into a new accept: always pass through IDLE first.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
